key_request_latch: RTL and testbench

//   Conditions the four raw direction push-buttons and holds the last valid press
//   as a one-hot request until the snake next steps. Sits directly upstream of
//   get_direction and drives its up/right/down/left inputs. Each press is held

---
 rtl/key_request_latch_if.sv | 32 +++
 rtl/key_request_latch.sv | 107 ++++++++++
 tb/tb_key_request_latch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/key_request_latch_if.sv
// Purpose: groups the button, move-tick and request signals of
//          key_request_latch into one bundle.
// Signals:
//   btn_up/right/down/left  raw push-buttons, active-high, asynchronous
//   move_tick               one-cycle pulse: the snake stepped, the pending request is used
//   up/right/down/left      one-hot (or all-zero) held direction request
//   key_valid               OR of the four request bits
// Modports:
//   master  drives the buttons and move_tick, observes the request
//   slave   the latch itself
interface key_request_latch_if;
  logic btn_up;
  logic btn_right;
  logic btn_down;
  logic btn_left;
  logic move_tick;
  logic up;
  logic right;
  logic down;
  logic left;
  logic key_valid;

  modport master (
    output btn_up, btn_right, btn_down, btn_left, move_tick,
    input  up, right, down, left, key_valid
  );

  modport slave (
    input  btn_up, btn_right, btn_down, btn_left, move_tick,
    output up, right, down, left, key_valid
  );
endinterface

// File: rtl/key_request_latch.sv
// Purpose: conditions the four raw direction buttons and keeps the most recent
//          debounced press as a one-hot request. The request is held until the
//          snake steps, so get_direction never misses a short press.
// Ports:
//   clock  system clock; all state changes on the rising edge
//   reset  asynchronous, active-high; clears every flop
//   kif    slave side of key_request_latch_if (buttons and move_tick in,
//          up/right/down/left/key_valid out)
// Parameters:
//   DEBOUNCE_CYCLES  stable synced cycles needed to accept a level change (>=2)
//   SYNC_STAGES      synchronizer depth per button (>=2)
// Bit order everywhere below is {up, right, down, left} = [3:0].
module key_request_latch #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input logic           clock,
  input logic           reset,
  key_request_latch_if.slave kif
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]                  btn_raw;
  logic [3:0][SYNC_STAGES-1:0] sync_q;
  logic [3:0]                  sync_x;
  logic [3:0]                  stable_q, stable_d;
  logic [3:0][CW-1:0]          cnt_q, cnt_d;
  logic [3:0]                  press;
  logic [3:0]                  req_q, req_d;
  logic                        key_valid_q, key_valid_d;

  assign btn_raw = {kif.btn_up, kif.btn_right, kif.btn_down, kif.btn_left};

  // The last flop of each chain is the synchronized level.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sync_x[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Debounce: a differing synced level must persist for DEBOUNCE_CYCLES
  // consecutive cycles before it is adopted. The press event is derived from
  // the next-state so that stable_x and req change on the same edge.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press    = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync_x[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync_x[i];
        cnt_d[i]    = '0;
        press[i]    = sync_x[i];  // only a 0->1 acceptance is a press
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Request: newest press replaces any pending one, up > right > down > left
  // when several land together. A press outranks a coincident move_tick.
  always_comb begin
    req_d = req_q;
    if (press[3]) begin
      req_d = 4'b1000;
    end else if (press[2]) begin
      req_d = 4'b0100;
    end else if (press[1]) begin
      req_d = 4'b0010;
    end else if (press[0]) begin
      req_d = 4'b0001;
    end else if (kif.move_tick) begin
      req_d = 4'b0000;
    end
    key_valid_d = |req_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      req_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
      end
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kif.up        = req_q[3];
  assign kif.right     = req_q[2];
  assign kif.down      = req_q[1];
  assign kif.left      = req_q[0];
  assign kif.key_valid = key_valid_q;

endmodule

// File: tb/tb_key_request_latch.sv
// Directed bench for key_request_latch with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// a raw edge reaches the request output 6 rising edges later.
module tb_key_request_latch;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  key_request_latch_if kif ();

  key_request_latch #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kif   (kif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] req_bus();
    return {kif.up, kif.right, kif.down, kif.left};
  endfunction

  task automatic release_all();
    kif.btn_up    = 1'b0;
    kif.btn_right = 1'b0;
    kif.btn_down  = 1'b0;
    kif.btn_left  = 1'b0;
    kif.move_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse_tick();
    kif.move_tick = 1'b1;
    step(1);
    kif.move_tick = 1'b0;
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    release_all();

    // Reset state
    step(2);
    check("reset_req", 32'(req_bus()), 32'h0);
    check("reset_kv", 32'(kif.key_valid), 32'h0);
    check("reset_cnt", 32'(dut.cnt_q), 32'h0);
    reset = 1'b0;

    // Left held: exactly 6 edges, held, consumed by move_tick, no repeat
    kif.btn_left = 1'b1;
    step(5);
    check("left_edge5", 32'(req_bus()), 32'h0);
    step(1);
    check("left_edge6", 32'(req_bus()), 32'h1);
    check("left_kv", 32'(kif.key_valid), 32'h1);
    step(20);
    check("left_held", 32'(req_bus()), 32'h1);
    pulse_tick();
    check("left_tick_req", 32'(req_bus()), 32'h0);
    check("left_tick_kv", 32'(kif.key_valid), 32'h0);
    step(10);
    check("left_no_repeat", 32'(req_bus()), 32'h0);
    release_all();
    do_reset();

    // Bouncing up: single event 6 edges after the final rise
    for (int k = 0; k < 4; k++) begin
      kif.btn_up = (k % 2 == 0);
      step(2);
    end
    kif.btn_up = 1'b1;
    step(5);
    check("bounce_edge5", 32'(req_bus()), 32'h0);
    step(1);
    check("bounce_edge6", 32'(req_bus()), 32'h8);
    step(10);
    check("bounce_single", 32'(req_bus()), 32'h8);
    release_all();
    do_reset();

    // 3-cycle glitch on down is rejected, counters drain to 0
    kif.btn_down = 1'b1;
    step(3);
    kif.btn_down = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      seen |= kif.down;
    end
    check("glitch3_down", 32'(seen), 32'h0);
    check("glitch3_cnt", 32'(dut.cnt_q), 32'h0);

    // 4-cycle pulse is exactly long enough to be accepted
    kif.btn_down = 1'b1;
    step(4);
    kif.btn_down = 1'b0;
    step(2);
    check("pulse4_down", 32'(req_bus()), 32'h2);
    step(10);
    check("pulse4_hold", 32'(req_bus()), 32'h2);
    do_reset();

    // Up then right without a tick: 1000 then 0100, never 1100
    kif.btn_up = 1'b1;
    step(6);
    check("seq_up", 32'(req_bus()), 32'h8);
    kif.btn_up = 1'b0;
    step(10);
    check("seq_up_after_release", 32'(req_bus()), 32'h8);
    kif.btn_right = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      seen |= (req_bus() == 4'b1100);
    end
    check("seq_never_both", 32'(seen), 32'h0);
    check("seq_right", 32'(req_bus()), 32'h4);
    release_all();
    do_reset();

    // Up and left together: priority up; held left gives no later event
    kif.btn_up   = 1'b1;
    kif.btn_left = 1'b1;
    step(6);
    check("prio_up", 32'(req_bus()), 32'h8);
    pulse_tick();
    check("prio_tick", 32'(req_bus()), 32'h0);
    step(10);
    check("prio_no_left", 32'(req_bus()), 32'h0);
    release_all();
    do_reset();

    // Press coincident with move_tick keeps the new bit
    kif.btn_right = 1'b1;
    step(5);
    kif.move_tick = 1'b1;
    step(1);
    kif.move_tick = 1'b0;
    check("coinc_req", 32'(req_bus()), 32'h4);
    check("coinc_kv", 32'(kif.key_valid), 32'h1);
    release_all();
    do_reset();

    // Reset mid-count then button released: no event
    kif.btn_down = 1'b1;
    step(4);
    reset = 1'b1;
    step(1);
    check("midrst_req", 32'(req_bus()), 32'h0);
    check("midrst_cnt", 32'(dut.cnt_q), 32'h0);
    kif.btn_down = 1'b0;
    reset = 1'b0;
    step(10);
    check("midrst_no_event", 32'(req_bus()), 32'h0);

    // Button held through reset release: exactly one event after debounce
    reset = 1'b1;
    kif.btn_left = 1'b1;
    step(2);
    check("held_rst_kv", 32'(kif.key_valid), 32'h0);
    reset = 1'b0;
    step(5);
    check("held_edge5", 32'(req_bus()), 32'h0);
    step(1);
    check("held_edge6", 32'(req_bus()), 32'h1);
    pulse_tick();
    step(10);
    check("held_once", 32'(req_bus()), 32'h0);
    release_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
